cam_line_capture: RTL and testbench

Producer side of the line-buffer interface consumed by pupil_detect. Takes the inward-camera pixel stream (one grayscale pixel per pixel_valid strobe, raster order), assembles each line into one of two ping-pong line banks, and presents completed lines to the detector with a ready/ack handshake. Also reports line number, frame completion and overflow, so the detector never sees a partially written line.

---
 rtl/cam_line_capture_pkg.sv | 7 +
 rtl/cam_line_capture_line_bank.sv | 18 +
 rtl/cam_line_capture.sv | 109 ++++++++++
 tb/tb_cam_line_capture.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cam_line_capture_pkg.sv
// cam_line_capture_pkg: line-buffer constants shared with pupil_detect, plus the capture FSM state encoding
package cam_line_capture_pkg;
  localparam int RESOLUTION  = 112;
  localparam int PIXEL_WIDTH = 8;
  localparam int ADDR_WIDTH  = 7;
  typedef enum logic [1:0] {IDLE, CAPTURE, DROP} state_t;
endpackage

// File: rtl/cam_line_capture_line_bank.sv
// line_bank: RESOLUTION x PIXEL_WIDTH line memory; ports clock, reset, we/waddr/wdata write, raddr/rdata registered read (out-of-range reads 0)
module line_bank
  import cam_line_capture_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   we,
  input  logic [ADDR_WIDTH-1:0]  waddr,
  input  logic [PIXEL_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0]  raddr,
  output logic [PIXEL_WIDTH-1:0] rdata
);
  logic [PIXEL_WIDTH-1:0] mem [RESOLUTION];
  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clock)
    rdata <= reset ? '0 : (raddr < ADDR_WIDTH'(RESOLUTION) ? mem[raddr] : '0);
endmodule

// File: rtl/cam_line_capture.sv
// cam_line_capture: ping-pong line capture; ports clock/reset, camera start/pixel stream in, rd_addr->rd_data, line_ready/line_number/line_ack handshake, frame_done, sticky overflow
module cam_line_capture
  import cam_line_capture_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cam_frame_capture_start,
  input  logic                   pixel_valid,
  input  logic [PIXEL_WIDTH-1:0] pixel_data,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [PIXEL_WIDTH-1:0] rd_data,
  output logic                   line_ready,
  output logic [7:0]             line_number,
  input  logic                   line_ack,
  output logic                   frame_done,
  output logic                   overflow
);
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] pix_cnt, pix_cnt_n;
  logic [7:0] wr_line, wr_line_n;
  logic [1:0][7:0] tag, tag_n;
  logic [1:0] full, full_n;
  logic wr_bank, wr_bank_n, pres, pres_n, rd_sel, overflow_n, frame_done_n, we, eol, ack;
  logic [PIXEL_WIDTH-1:0] rdata [2];
  assign line_ready  = full[pres];
  assign line_number = tag[pres];
  assign rd_data     = rdata[rd_sel];
  assign ack         = line_ready && line_ack;
  assign we          = pixel_valid && (cam_frame_capture_start || state == CAPTURE);
  assign eol         = pixel_valid && state != IDLE && pix_cnt == ADDR_WIDTH'(RESOLUTION - 1);
  for (genvar i = 0; i < 2; i++) begin : g_bank
    line_bank u_bank (
      .clock (clock),
      .reset (reset),
      .we    (we && (cam_frame_capture_start ? 1'b0 : wr_bank) == 1'(i)),
      .waddr (cam_frame_capture_start ? '0 : pix_cnt),
      .wdata (pixel_data),
      .raddr (rd_addr),
      .rdata (rdata[i])
    );
  end
  // pres always points at the oldest full bank, or at the bank that will fill next when none is full
  always_comb begin
    state_n      = state;
    pix_cnt_n    = pix_cnt;
    wr_line_n    = wr_line;
    tag_n        = tag;
    full_n       = full;
    wr_bank_n    = wr_bank;
    pres_n       = pres;
    overflow_n   = overflow;
    frame_done_n = 1'b0;
    if (ack) begin
      full_n[pres] = 1'b0;
      pres_n       = ~pres;
    end
    if (cam_frame_capture_start) begin
      state_n    = CAPTURE;
      pix_cnt_n  = ADDR_WIDTH'(pixel_valid);
      wr_line_n  = '0;
      full_n     = '0;
      wr_bank_n  = 1'b0;
      pres_n     = 1'b0;
      overflow_n = 1'b0;
    end else if (state != IDLE && pixel_valid) begin
      pix_cnt_n = eol ? '0 : pix_cnt + 1'b1;
      if (eol) begin
        wr_line_n = wr_line + 1'b1;
        if (state == CAPTURE) begin
          full_n[wr_bank] = 1'b1;
          tag_n[wr_bank]  = wr_line;
        end else overflow_n = 1'b1;
        // a bank acked in this same cycle already counts as empty here, so nothing is dropped
        if (wr_line == 8'(RESOLUTION - 1)) begin
          state_n      = IDLE;
          frame_done_n = 1'b1;
        end else if (&full_n) state_n = DROP;
        else begin
          state_n   = CAPTURE;
          wr_bank_n = full_n[pres_n] ? ~pres_n : pres_n;
        end
      end
    end
  end
  always_ff @(posedge clock)
    if (reset) begin
      state      <= IDLE;
      pix_cnt    <= '0;
      wr_line    <= '0;
      tag        <= '0;
      full       <= '0;
      wr_bank    <= 1'b0;
      pres       <= 1'b0;
      rd_sel     <= 1'b0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      pix_cnt    <= pix_cnt_n;
      wr_line    <= wr_line_n;
      tag        <= tag_n;
      full       <= full_n;
      wr_bank    <= wr_bank_n;
      pres       <= pres_n;
      rd_sel     <= pres;
      overflow   <= overflow_n;
      frame_done <= frame_done_n;
    end
endmodule

// File: tb/tb_cam_line_capture.sv
// tb_cam_line_capture: randomized scoreboard bench for cam_line_capture against a line-level reference model
module tb_cam_line_capture;
  import cam_line_capture_pkg::*;
  logic clock = 0, reset = 1, cam_frame_capture_start = 0, pixel_valid = 0, line_ack = 0;
  logic [7:0] pixel_data = 0, rd_data, line_number;
  logic [6:0] rd_addr = 0;
  logic line_ready, frame_done, overflow;
  int tests = 0, fails = 0, ack_pct = 0, gap_pct = 0, force_addr = -1;
  int m_held = 0, m_line = 0, m_pix = 0, cur = -1, pcur = -1;
  bit m_active = 0, m_capt = 0, m_ovf = 0, m_fd = 0, rp = 0;
  int exp_q[$];
  logic [7:0] pix_mem [RESOLUTION][RESOLUTION];

  always #5 clock = ~clock;

  cam_line_capture dut (
    .clock                   (clock),
    .reset                   (reset),
    .cam_frame_capture_start (cam_frame_capture_start),
    .pixel_valid             (pixel_valid),
    .pixel_data              (pixel_data),
    .rd_addr                 (rd_addr),
    .rd_data                 (rd_data),
    .line_ready              (line_ready),
    .line_number             (line_number),
    .line_ack                (line_ack),
    .frame_done              (frame_done),
    .overflow                (overflow)
  );

  task automatic chk(input string name, input int act, input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: counts lines held by the consumer (presented + waiting, max 2).
  // A line is kept iff fewer than two lines are held when it starts.
  initial forever begin
    @(posedge clock);
    m_fd = 0;
    if (reset) begin
      m_held = 0; m_active = 0; m_ovf = 0; exp_q.delete();
    end else begin
      if (line_ack && m_held > 0) m_held--;
      if (cam_frame_capture_start) begin
        m_held = 0; exp_q.delete(); m_ovf = 0; m_active = 1; m_capt = 1; m_line = 0; m_pix = 0;
      end
      if (m_active && pixel_valid) begin
        if (m_capt) pix_mem[m_line][m_pix] = pixel_data;
        if (m_pix == RESOLUTION - 1) begin
          if (m_capt) begin m_held++; exp_q.push_back(m_line); end
          else m_ovf = 1;
          m_capt = m_held < 2;
          m_pix = 0;
          if (m_line == RESOLUTION - 1) begin m_fd = 1; m_active = 0; end
          m_line++;
        end else m_pix++;
      end
    end
  end

  // Monitor: per-cycle control checks; pops the scoreboard whenever a new line is presented
  initial forever begin
    @(posedge clock); #1;
    chk("line_ready", line_ready, m_held > 0);
    chk("overflow", overflow, m_ovf);
    chk("frame_done", frame_done, m_fd);
    if (reset) begin
      chk("reset_rd_data", rd_data, 0);
      chk("reset_line_number", line_number, 0);
    end else if (rp && pcur >= 0 && !cam_frame_capture_start)
      chk("rd_data", rd_data, rd_addr < RESOLUTION ? pix_mem[pcur][rd_addr] : 0);
    if (line_ready && (!rp || line_ack)) begin
      if (exp_q.size() == 0) begin
        tests++; fails++; cur = -1;
        $display("FAIL line_number: presented %0d, expected no line at %0t", line_number, $time);
      end else begin
        cur = exp_q.pop_front();
        chk("line_number", line_number, cur);
      end
    end
    rp = line_ready;
    pcur = cur;
  end

  task automatic tick(input bit st, input bit pv, input logic [7:0] pd, input bit ackf);
    @(negedge clock);
    cam_frame_capture_start = st;
    pixel_valid = pv;
    pixel_data = pd;
    line_ack = ackf || ($urandom_range(99) < ack_pct);
    rd_addr = force_addr >= 0 ? 7'(force_addr) : 7'($urandom_range(127));
  endtask

  task automatic feed(input int n, input bit idx_pat, input bit ack_last);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < gap_pct) tick(0, 0, 8'($urandom), 0);
      tick(0, 1, idx_pat ? 8'(i % RESOLUTION) : 8'($urandom), ack_last && i == n - 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 8'd0, 0);
  endtask

  initial begin
    repeat (2) tick(0, 0, 8'd0, 0);
    reset = 0;
    repeat (5) tick(0, 1, 8'($urandom), 0);
    idle(2);
    // one line with pixel value = index, explicit in/out-of-range reads
    tick(1, 0, 8'd0, 0);
    feed(RESOLUTION, 1, 0);
    force_addr = 5;   idle(3);
    force_addr = 120; idle(3);
    force_addr = -1;  ack_pct = 100; idle(2);
    // full frame with prompt acks, then pixels while idle
    ack_pct = 40; gap_pct = 5;
    tick(1, 0, 8'd0, 0);
    feed(RESOLUTION * RESOLUTION, 0, 0);
    idle(20);
    feed(20, 0, 0);
    ack_pct = 100; idle(5);
    // no acks: lines 0,1 held, line 2 dropped; one ack late in line 2 lets line 3 be kept
    ack_pct = 0; gap_pct = 0;
    tick(1, 0, 8'd0, 0);
    feed(2 * RESOLUTION + 100, 0, 0);
    tick(0, 0, 8'd0, 1);
    feed(RESOLUTION - 100, 0, 0);
    idle(3);
    ack_pct = 50;
    feed(RESOLUTION, 0, 0);
    idle(30);
    // ack of line 0 in the same cycle line 1 completes
    ack_pct = 0;
    tick(1, 0, 8'd0, 0);
    feed(RESOLUTION, 0, 0);
    feed(RESOLUTION, 0, 1);
    idle(3);
    ack_pct = 60; idle(20);
    // restart mid-line with overflow set, restart pixel becomes pixel 0 of line 0
    ack_pct = 0;
    tick(1, 0, 8'd0, 0);
    feed(3 * RESOLUTION + 50, 0, 0);
    tick(1, 1, 8'($urandom), 0);
    feed(RESOLUTION - 1, 0, 0);
    idle(3);
    ack_pct = 50; idle(20);
    // randomized frames with random gaps, ack rates and occasional restarts
    repeat (4) begin
      ack_pct = $urandom_range(60);
      gap_pct = $urandom_range(30);
      tick(1, $urandom_range(1), 8'($urandom), 0);
      feed($urandom_range(200, 700), 0, 0);
    end
    ack_pct = 100; gap_pct = 0;
    idle(10);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
